// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command/writeback sequencer around a combinational 16-bit ALU
// Define ALU_SEQ_OPCOUNT_EN to add the op_count result-handshake counter.
module alu_op_sequencer #(
  parameter int DW      = 16,
  parameter int RW      = 32,
  parameter int ALU_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_sel,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  input  logic          cmd_use_acc,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_sel,
  input  logic [RW-1:0] alu_out,
  input  logic          alu_err,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [RW-1:0] res_data,
  output logic          res_err,
  output logic [RW-1:0] acc_out,
`ifdef ALU_SEQ_OPCOUNT_EN
  output logic [15:0]   op_count,
`endif
  output logic          err_sticky
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_cnt;
  logic [DW-1:0] r_alu_a, r_alu_b;
  logic [3:0]    r_alu_sel;
  logic [RW-1:0] r_res_data, r_acc;
  logic          r_res_err, r_err_sticky;
  logic          w_accept, w_legal, w_clear, w_capture;

  assign cmd_ready = (r_state == S_IDLE) & ~reset;
  assign res_valid = (r_state == S_DONE);
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_clear   = (cmd_sel == 4'd0);
  assign w_legal   = (cmd_sel >= 4'd1) && (cmd_sel <= 4'd12);
  assign w_capture = (r_state == S_EXEC) && (r_cnt == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_legal ? S_EXEC : S_DONE;
      S_EXEC: if (r_cnt == 4'd0) w_state_nxt = S_DONE;
      S_DONE: if (res_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sel    <= '0;
      r_res_data   <= '0;
      r_acc        <= '0;
      r_res_err    <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_legal) begin
          r_alu_a   <= cmd_use_acc ? r_acc[DW-1:0] : cmd_a;
          r_alu_b   <= cmd_b;
          r_alu_sel <= cmd_sel;
          r_cnt     <= 4'(ALU_LAT - 1);
        end else if (w_clear) begin
          r_alu_sel    <= 4'd0;
          r_res_data   <= '0;
          r_acc        <= '0;
          r_res_err    <= 1'b0;
          r_err_sticky <= 1'b0;
        end else begin
          // Illegal opcode: flag the error but leave accumulator and ALU inputs alone.
          r_res_data   <= '0;
          r_res_err    <= 1'b1;
          r_err_sticky <= 1'b1;
        end
      end else if (w_capture) begin
        r_res_data   <= alu_out;
        r_acc        <= alu_out;
        r_res_err    <= alu_err;
        r_err_sticky <= r_err_sticky | alu_err;
      end else if (r_state == S_EXEC) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

`ifdef ALU_SEQ_OPCOUNT_EN
  logic [15:0] r_op_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        r_op_count <= 16'd0;
    else if (res_valid && res_ready)  r_op_count <= r_op_count + 16'd1;
  end

  assign op_count = r_op_count;
`endif

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign res_data   = r_res_data;
  assign res_err    = r_res_err;
  assign acc_out    = r_acc;
  assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer
// Build with ALU_SEQ_OPCOUNT_EN defined to also exercise op_count.
module tb_alu_op_sequencer;
  localparam int DW  = 16;
  localparam int RW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_use_acc;
  logic [3:0]    cmd_sel, alu_sel;
  logic [DW-1:0] cmd_a, cmd_b, alu_a, alu_b;
  logic [RW-1:0] alu_out, res_data, acc_out;
  logic          alu_err, res_valid, res_ready, res_err, err_sticky;
`ifdef ALU_SEQ_OPCOUNT_EN
  logic [15:0]   op_count;
`endif

  alu_op_sequencer #(.DW(DW), .RW(RW), .ALU_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_err(alu_err),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .acc_out(acc_out),
`ifdef ALU_SEQ_OPCOUNT_EN
    .op_count(op_count),
`endif
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Environment ALU: returns {err, result}
  function automatic logic [RW:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [3:0] sel);
    logic [RW-1:0] r;
    logic          e;
    r = '0;
    e = 1'b0;
    case (sel)
      4'd1:  r = {16'h0, ~a};
      4'd2:  r = {16'h0, a} >> b[3:0];
      4'd3:  r = {16'h0, a} << b[3:0];
      4'd4:  if (a > 16'd12) e = 1'b1;
             else begin
               r = 32'd1;
               for (int i = 2; i <= int'(a); i++) r = r * 32'(i);
             end
      4'd5:  begin
               r = 32'd1;
               for (int i = 0; i < int'(b[2:0]); i++) r = r * {16'h0, a};
             end
      4'd6:  r = {16'h0, a} + {16'h0, b};
      4'd7:  begin r = {16'h0, a} - {16'h0, b}; e = (b > a); end
      4'd8:  r = {16'h0, a} * {16'h0, b};
      4'd9:  if (b == 16'd0) e = 1'b1; else r = {16'h0, a / b};
      4'd10: r = {16'h0, a & b};
      4'd11: r = {16'h0, a | b};
      4'd12: r = {16'h0, a ^ b};
      default: r = '0;
    endcase
    return {e, r};
  endfunction

  assign {alu_err, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

  // Reference model state
  logic [RW-1:0] m_acc, m_res;
  logic          m_sticky, m_rerr;
  logic [DW-1:0] m_a, m_b;
  logic [3:0]    m_sel;
  logic [15:0]   m_cnt;
  int            m_lat;

  task automatic model_reset();
    m_acc = '0; m_res = '0; m_sticky = 1'b0; m_rerr = 1'b0;
    m_a = '0; m_b = '0; m_sel = '0; m_cnt = '0; m_lat = 0;
  endtask

  task automatic model_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [3:0] sel, input logic ua);
    logic [DW-1:0] ea;
    ea = ua ? m_acc[DW-1:0] : a;
    if (sel == 4'd0) begin
      m_res = '0; m_rerr = 1'b0; m_acc = '0; m_sticky = 1'b0; m_sel = 4'd0; m_lat = 1;
    end else if (sel > 4'd12) begin
      m_res = '0; m_rerr = 1'b1; m_sticky = 1'b1; m_lat = 1;
    end else begin
      {m_rerr, m_res} = alu_fn(ea, b, sel);
      m_acc = m_res; m_sticky = m_sticky | m_rerr;
      m_a = ea; m_b = b; m_sel = sel; m_lat = LAT + 1;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after acceptance
  task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [3:0] sel, input logic ua);
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_use_acc = ua; cmd_valid = 1'b1;
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL issue_ready: got %0b want 1", cmd_ready);
    end
    @(posedge clk);
    model_cmd(a, b, sel, ua);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_a = DW'($urandom); cmd_b = DW'($urandom); cmd_sel = 4'($urandom);
    cmd_use_acc = 1'($urandom);
    n_vec++;
    if ({alu_a, alu_b, alu_sel} !== {m_a, m_b, m_sel}) begin
      n_err++; $display("FAIL alu_regs: got %h want %h", {alu_a, alu_b, alu_sel}, {m_a, m_b, m_sel});
    end
  endtask

  task automatic wait_result();
    int k;
    k = 1;
    while (res_valid !== 1'b1 && k <= 20) begin
      n_vec++;
      if (cmd_ready !== 1'b0) begin
        n_err++; $display("FAIL busy_ready: got %0b want 0", cmd_ready);
      end
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (k !== m_lat) begin
      n_err++; $display("FAIL latency: got %0d want %0d", k, m_lat);
    end
    n_vec++;
    if ({res_data, res_err, acc_out, err_sticky, cmd_ready} !== {m_res, m_rerr, m_acc, m_sticky, 1'b0}) begin
      n_err++; $display("FAIL result: got %h/%b/%h/%b/%b want %h/%b/%h/%b/0",
                        res_data, res_err, acc_out, err_sticky, cmd_ready, m_res, m_rerr, m_acc, m_sticky);
    end
  endtask

  task automatic handshake(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_vec++;
      if ({res_valid, res_data, res_err} !== {1'b1, m_res, m_rerr}) begin
        n_err++; $display("FAIL hold: got %b/%h/%b want 1/%h/%b", res_valid, res_data, res_err, m_res, m_rerr);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    m_cnt = m_cnt + 16'd1;
    n_vec++;
    if ({res_valid, cmd_ready} !== 2'b01) begin
      n_err++; $display("FAIL post_hs: got valid=%b ready=%b want 0/1", res_valid, cmd_ready);
    end
`ifdef ALU_SEQ_OPCOUNT_EN
    n_vec++;
    if (op_count !== m_cnt) begin
      n_err++; $display("FAIL op_count: got %0d want %0d", op_count, m_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b1; res_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_sel = 4'd6; cmd_use_acc = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if ({cmd_ready, res_valid, res_data, res_err, acc_out, err_sticky, alu_a, alu_b, alu_sel} !== '0) begin
      n_err++; $display("FAIL reset_state: got ready=%b valid=%b acc=%h alu_a=%h", cmd_ready, res_valid, acc_out, alu_a);
    end
    cmd_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({cmd_ready, res_valid} !== 2'b10) begin
      n_err++; $display("FAIL reset_release: got %b%b want 10", cmd_ready, res_valid);
    end
  endtask

  task automatic test_add_timing();
    issue(16'd3, 16'd4, 4'd6, 1'b0);
    wait_result();
    n_vec++;
    if ({res_data, acc_out, res_err} !== {32'd7, 32'd7, 1'b0}) begin
      n_err++; $display("FAIL add_value: got %0d/%0d/%b want 7/7/0", res_data, acc_out, res_err);
    end
    handshake(0);
  endtask

  task automatic test_acc_chain();
    issue(16'hBEEF, 16'd5, 4'd8, 1'b1);
    wait_result();
    n_vec++;
    if ({res_data, acc_out} !== {32'd35, 32'd35}) begin
      n_err++; $display("FAIL chain_value: got %0d/%0d want 35/35", res_data, acc_out);
    end
    handshake(1);
  endtask

  task automatic test_illegal_clear();
    issue(16'd1, 16'd1, 4'd13, 1'b0);
    wait_result();
    n_vec++;
    if ({res_data, res_err, err_sticky, acc_out} !== {32'd0, 1'b1, 1'b1, 32'd35}) begin
      n_err++; $display("FAIL illegal: got %h/%b/%b/%0d want 0/1/1/35", res_data, res_err, err_sticky, acc_out);
    end
    handshake(0);
    issue(16'd9, 16'd9, 4'd0, 1'b0);
    wait_result();
    n_vec++;
    if ({acc_out, err_sticky, alu_sel} !== {32'd0, 1'b0, 4'd0}) begin
      n_err++; $display("FAIL clear: got %h/%b/%h want 0/0/0", acc_out, err_sticky, alu_sel);
    end
    handshake(0);
  endtask

  task automatic test_random();
    logic [3:0] sel;
    for (int n = 0; n < 40; n++) begin
      sel = 4'($urandom_range(0, 15));
      issue(DW'($urandom), DW'($urandom_range(0, 40)), sel, 1'($urandom));
      wait_result();
      handshake(int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_backpressure();
    issue(16'd10, 16'd3, 4'd7, 1'b0);
    wait_result();
    cmd_a = 16'd100; cmd_b = 16'd2; cmd_sel = 4'd6; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if ({res_valid, res_data, res_err, cmd_ready, alu_a, alu_sel} !== {1'b1, m_res, m_rerr, 1'b0, m_a, m_sel}) begin
        n_err++; $display("FAIL backpressure: got %b/%h/%b/%b/%h want 1/%h/%b/0/%h",
                          res_valid, res_data, res_err, cmd_ready, alu_a, m_res, m_rerr, m_a);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    m_cnt = m_cnt + 16'd1;
    n_vec++;
    if ({res_valid, cmd_ready, alu_a, alu_sel} !== {1'b0, 1'b1, m_a, m_sel}) begin
      n_err++; $display("FAIL bp_release: got %b/%b/%h/%h want 0/1/%h/%h", res_valid, cmd_ready, alu_a, alu_sel, m_a, m_sel);
    end
    @(posedge clk);
    model_cmd(16'd100, 16'd2, 4'd6, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    n_vec++;
    if ({alu_a, alu_b, alu_sel} !== {16'd100, 16'd2, 4'd6}) begin
      n_err++; $display("FAIL bp_accept: got %h want 0064/0002/6", {alu_a, alu_b, alu_sel});
    end
    wait_result();
    handshake(1);
  endtask

  task automatic test_reset_mid();
    issue(16'd20, 16'd6, 4'd8, 1'b0);
    reset = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if ({cmd_ready, res_valid, res_data, res_err, acc_out, err_sticky, alu_a, alu_b, alu_sel} !== '0) begin
      n_err++; $display("FAIL reset_mid: got ready=%b valid=%b acc=%h alu_a=%h", cmd_ready, res_valid, acc_out, alu_a);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++;
    if ({cmd_ready, res_valid, acc_out} !== {1'b1, 1'b0, 32'd0}) begin
      n_err++; $display("FAIL reset_mid_release: got %b/%b/%h want 1/0/0", cmd_ready, res_valid, acc_out);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if ({res_valid, acc_out} !== {1'b0, 32'd0}) begin
      n_err++; $display("FAIL reset_mid_idle: got %b/%h want 0/0", res_valid, acc_out);
    end
  endtask

`ifdef ALU_SEQ_OPCOUNT_EN
  task automatic test_opcount();
    issue(16'd2, 16'd3, 4'd6, 1'b0); wait_result(); handshake(0);
    issue(16'd0, 16'd0, 4'd0, 1'b0); wait_result(); handshake(0);
    issue(16'd7, 16'd1, 4'd12, 1'b1); wait_result(); handshake(0);
    n_vec++;
    if (op_count !== 16'd3) begin
      n_err++; $display("FAIL op_count3: got %0d want 3", op_count);
    end
    force dut.r_op_count = 16'hFFFF;
    #1;
    release dut.r_op_count;
    m_cnt = 16'hFFFF;
    @(negedge clk);
    issue(16'd1, 16'd1, 4'd14, 1'b0); wait_result(); handshake(0);
    n_vec++;
    if (op_count !== 16'd0) begin
      n_err++; $display("FAIL op_count_wrap: got %0d want 0", op_count);
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_timing();
    test_acc_chain();
    test_illegal_clear();
    test_random();
    test_backpressure();
    test_reset_mid();
`ifdef ALU_SEQ_OPCOUNT_EN
    test_opcount();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
